cross_arbiter: RTL
==================

CROSS_ARBITER -- requirements
Module: cross_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports req0/req1, input, 1 bit each: requester i presents an operation.
REQ-004 SHALL have ports lock0/lock1, input, 1 bit each: requester i asks to keep the grant for a burst.
REQ-005 SHALL have ports ax0, ay0, bx0, by0, ax1, ay1, bx1, by1, input, 11 bits signed each: operands of requester i.
REQ-006 SHALL have ports gnt0/gnt1, output, 1 bit each: combinational grant; operation accepted at the rising edge where req_i && gnt_i.
REQ-007 SHALL have ports rsp_valid0/rsp_valid1, output, 1 bit each, registered: result for requester i is valid this cycle.
REQ-008 SHALL have ports rsp_gt, rsp_eq, output, 1 bit each, registered: (ax*by > bx*ay), (ax*by == bx*ay).
REQ-009 SHALL have port busy, output, 1 bit: any pipeline stage holds a valid operation.

Function
REQ-010 SHALL assert at most one of gnt0/gnt1 per cycle; gnt_i SHALL be 0 when req_i is 0.
REQ-011 SHALL, with only one requester active, grant that requester in the same cycle, subject to REQ-014.
REQ-012 SHALL, with both requesting and no active lock, grant the requester favored by the round-robin pointer rp.
REQ-013 SHALL, after each accepted operation from requester i, set rp to favor the other requester.
REQ-014 SHALL enter lock-owner mode for requester i when it is granted with lock_i=1.
- In lock-owner mode, SHALL grant only i while lock_i=1, even if the other requester is active.
- Lock-owner mode SHALL end when lock_i=0 or req_i=0 in a cycle.
REQ-015 SHALL count consecutive lock-mode grants to i with a 4-bit counter.
- After the 8th consecutive grant, if the other requester is requesting, SHALL force one grant to it, then clear the counter.
- Lock-owner mode SHALL end after a forced grant; requester i then re-arbitrates normally.
REQ-016 SHALL clear the burst counter whenever lock-owner mode ends.
REQ-017 SHALL pipeline each accepted operation in 3 stages: S1 registers operands plus 1-bit tag; S2 registers two 22-bit signed products; S3 registers the compare results into rsp_gt, rsp_eq and rsp_valid_tag.
REQ-018 SHALL compute products at full 22-bit signed precision with no truncation or overflow for all 11-bit signed inputs.
REQ-019 SHALL, for an operation accepted at edge k, assert rsp_valid_tag for exactly the one cycle following edge k+2.
REQ-020 SHALL sustain one accepted operation per cycle with no stall and no response backpressure.
REQ-021 SHALL hold rsp_gt and rsp_eq at 0 in any cycle where neither rsp_valid is 1.
REQ-022 SHALL assert busy when any of S1, S2 or S3 holds a valid operation.

Reset
REQ-023 SHALL, while reset=1 at a rising edge, clear all pipeline valid bits, rsp_valid0/1, rsp_gt, rsp_eq, busy, the lock state and the burst counter, and set rp to favor requester 0.
REQ-024 SHALL drop operations in flight at reset; no rsp_valid SHALL appear for them.
REQ-025 SHALL hold gnt0/gnt1 at 0 during cycles with reset=1.

Verification
REQ-026 SHALL pass: req0 with ax0=3, by0=4, bx0=1, ay0=2 accepted at edge k -> rsp_valid0=1, rsp_gt=1, rsp_eq=0 in the cycle after edge k+2 only.
REQ-027 SHALL pass: req1 with ax1=-1024, by1=-1024, bx1=1023, ay1=1023 -> rsp_valid1=1, rsp_gt=1 (1048576 > 1046529).
REQ-028 SHALL pass: req0 and req1 both held high from the first cycle after reset, lock off -> gnt0, gnt1, gnt0, gnt1 alternating; responses return in the same order, one per cycle.
REQ-029 SHALL pass: req0, lock0 and req1 all held high -> gnt0 for 8 cycles, gnt1 for 1 cycle, then the 8+1 pattern repeats.
REQ-030 SHALL pass: ax0=2, by0=6, bx0=3, ay0=4 -> rsp_gt=0, rsp_eq=1.
REQ-031 SHALL pass: operation accepted at edge k, reset=1 at edge k+1 -> no rsp_valid, busy=0 after that edge, next grant goes to requester 0.

Source files
------------

// File: rtl/cross_arbiter.sv
// cross_arbiter: two-requester round-robin arbiter with lock bursts feeding a 3-stage cross-product compare pipeline.
module cross_arbiter (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               lock0,
  input  logic               lock1,
  input  logic signed [10:0] ax0,
  input  logic signed [10:0] ay0,
  input  logic signed [10:0] bx0,
  input  logic signed [10:0] by0,
  input  logic signed [10:0] ax1,
  input  logic signed [10:0] ay1,
  input  logic signed [10:0] bx1,
  input  logic signed [10:0] by1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rsp_valid0,
  output logic               rsp_valid1,
  output logic               rsp_gt,
  output logic               rsp_eq,
  output logic               busy
);
  logic [1:0] req, lck;
  logic rp, own, own_id, hold, force_o, pick, any;
  logic [3:0] cnt;
  logic v1, t1, v2, t2;
  logic signed [10:0] a_x, a_y, b_x, b_y;
  logic signed [21:0] p_l, p_r;
  assign req = {req1, req0};
  assign lck = {lock1, lock0};
  always_comb begin
    hold    = own && req[own_id] && lck[own_id];
    force_o = hold && cnt >= 4'd8 && req[!own_id];
    pick    = force_o ? !own_id : hold ? own_id : (&req) ? rp : req[1];
    any     = !reset && |req;
    gnt0    = any && !pick;
    gnt1    = any && pick;
    busy    = v1 || v2 || rsp_valid0 || rsp_valid1;
  end
  // A burst counts its entry grant, so 8 owner grants precede the forced one; the count saturates while the other side is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rp     <= 1'b0;
      own    <= 1'b0;
      own_id <= 1'b0;
      cnt    <= 4'd0;
    end else if (!any) begin
      own <= 1'b0;
      cnt <= 4'd0;
    end else begin
      rp <= !pick;
      if (force_o) begin
        own <= 1'b0;
        cnt <= 4'd0;
      end else if (hold) begin
        cnt <= (cnt >= 4'd8) ? 4'd8 : cnt + 4'd1;
      end else begin
        own    <= lck[pick];
        own_id <= pick;
        cnt    <= lck[pick] ? 4'd1 : 4'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    a_x <= pick ? ax1 : ax0;
    a_y <= pick ? ay1 : ay0;
    b_x <= pick ? bx1 : bx0;
    b_y <= pick ? by1 : by0;
    t1  <= pick;
    t2  <= t1;
    p_l <= a_x * b_y;
    p_r <= b_x * a_y;
    if (reset) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_gt     <= 1'b0;
      rsp_eq     <= 1'b0;
    end else begin
      v1         <= any;
      v2         <= v1;
      rsp_valid0 <= v2 && !t2;
      rsp_valid1 <= v2 && t2;
      rsp_gt     <= v2 && (p_l > p_r);
      rsp_eq     <= v2 && (p_l == p_r);
    end
  end
endmodule
